fpnew_fma_sum_norm: RTL and testbench



---
 rtl/fpnew_fma_sum_norm.sv | 133 +++++++++++++
 tb/tb_fpnew_fma_sum_norm.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fpnew_fma_sum_norm.sv
// fpnew_fma_sum_norm: two-stage FMA adder/normalizer producing pre-rounding mantissa, exponent, round and sticky.
// Rounding modes use the fpnew 3-bit encoding (RNE=0, RTZ=1, RDN=2, RUP=3, RMM=4).
module fpnew_fma_sum_norm #(
    parameter int unsigned ExpWidth = 10,
    parameter int unsigned PrecBits = 24,
    parameter type TagType = logic,
    parameter type AuxType = logic,
    localparam int unsigned W = 3 * PrecBits + 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       effective_subtraction_i,
    input  logic                       tentative_sign_i,
    input  logic signed [ExpWidth-1:0] tentative_exponent_i,
    input  logic                       sticky_before_add_i,
    input  logic [W-1:0]               product_shifted_i,
    input  logic [W-1:0]               addend_shifted_i,
    input  logic                       inject_carry_in_i,
    input  logic [2:0]                 rnd_mode_i,
    input  TagType                     tag_i,
    input  AuxType                     aux_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic                       flush_i,
    output logic                       sign_o,
    output logic signed [ExpWidth-1:0] exponent_o,
    output logic [PrecBits-1:0]        mantissa_o,
    output logic                       round_bit_o,
    output logic                       sticky_bit_o,
    output logic                       zero_o,
    output logic [2:0]                 rnd_mode_o,
    output TagType                     tag_o,
    output AuxType                     aux_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic                       busy_o
);
    localparam logic [2:0] RNE = 3'd0;
    localparam logic [2:0] RDN = 3'd2;

    logic [1:0]                 valid_q;
    logic                       ready_a, ready_b;
    logic [W:0]                 raw, mag_d, mag_q;
    logic                       sign_a_d, sign_a_q, sticky_a_q;
    logic signed [ExpWidth-1:0] exp_a_q;
    logic [2:0]                 rnd_a_q;
    TagType                     tag_a_q;
    AuxType                     aux_a_q;
    int                         lzc, e_unc, shift;
    logic                       clamp, zero_d, sign_d;
    logic [W:0]                 norm;
    logic signed [ExpWidth-1:0] exp_d;

    assign ready_b    = out_ready_i | ~valid_q[1];
    assign ready_a    = ready_b | ~valid_q[0];
    assign in_ready_o = ready_a;
    assign out_valid_o = valid_q[1];
    assign busy_o     = in_valid_i | valid_q[0] | valid_q[1];

    // A negative subtraction result is recovered by negating the truncated sum and flipping the sign.
    always_comb begin
        raw      = {1'b0, product_shifted_i} + {1'b0, addend_shifted_i} + {{W{1'b0}}, inject_carry_in_i};
        mag_d    = raw;
        sign_a_d = tentative_sign_i;
        if (effective_subtraction_i) begin
            mag_d    = raw[W] ? {1'b0, raw[W-1:0]} : {1'b0, -raw[W-1:0]};
            sign_a_d = raw[W] ? tentative_sign_i : ~tentative_sign_i;
        end
    end

    // Shift is limited so the exponent bottoms out at zero for subnormal results.
    always_comb begin
        lzc = int'(W) + 1;
        for (int i = 0; i <= int'(W); i++)
            if (mag_q[i]) lzc = int'(W) - i;
        e_unc  = int'(exp_a_q) + 1 - lzc;
        clamp  = e_unc < 1;
        shift  = clamp ? ((exp_a_q > 0) ? int'(exp_a_q) : 0) : lzc;
        norm   = mag_q << shift;
        zero_d = mag_q == '0;
        exp_d  = (clamp | zero_d) ? '0 : ExpWidth'(e_unc);
        sign_d = (zero_d & ~sticky_a_q) ? (rnd_a_q == RDN) : sign_a_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q      <= '0;
            mag_q        <= '0;
            sign_a_q     <= 1'b0;
            exp_a_q      <= '0;
            sticky_a_q   <= 1'b0;
            rnd_a_q      <= RNE;
            tag_a_q      <= '0;
            aux_a_q      <= '0;
            sign_o       <= 1'b0;
            exponent_o   <= '0;
            mantissa_o   <= '0;
            round_bit_o  <= 1'b0;
            sticky_bit_o <= 1'b0;
            zero_o       <= 1'b0;
            rnd_mode_o   <= RNE;
            tag_o        <= '0;
            aux_o        <= '0;
        end else begin
            if (flush_i) begin
                valid_q <= '0;
            end else begin
                if (ready_a) valid_q[0] <= in_valid_i;
                if (ready_b) valid_q[1] <= valid_q[0];
            end
            if (ready_a & in_valid_i) begin
                mag_q      <= mag_d;
                sign_a_q   <= sign_a_d;
                exp_a_q    <= tentative_exponent_i;
                sticky_a_q <= sticky_before_add_i;
                rnd_a_q    <= rnd_mode_i;
                tag_a_q    <= tag_i;
                aux_a_q    <= aux_i;
            end
            if (ready_b & valid_q[0]) begin
                sign_o       <= sign_d;
                exponent_o   <= exp_d;
                mantissa_o   <= norm[W -: PrecBits];
                round_bit_o  <= norm[W-PrecBits];
                sticky_bit_o <= (|norm[W-PrecBits-1:0]) | sticky_a_q;
                zero_o       <= zero_d;
                rnd_mode_o   <= rnd_a_q;
                tag_o        <= tag_a_q;
                aux_o        <= aux_a_q;
            end
        end
    end
endmodule

// File: tb/tb_fpnew_fma_sum_norm.sv
// tb_fpnew_fma_sum_norm: directed and randomized checks of the sum/normalize stage against a reference model.
module tb_fpnew_fma_sum_norm;
    typedef struct {
        logic es, ts, sb, c, tag, aux;
        logic signed [9:0] te;
        logic [75:0] p, a;
        logic [2:0] rm;
    } op_t;

    logic clk = 1'b0, rst_n = 1'b0;
    logic es, ts, sb, c, tag_i, aux_i, in_valid, in_ready, flush, out_ready, out_valid, busy;
    logic signed [9:0] te, exponent_o;
    logic [75:0] p, a;
    logic [2:0] rm_i, rm_o;
    logic sign_o, round_o, sticky_o, zero_o, tag_o, aux_o;
    logic [23:0] mant_o;
    int n_cmp = 0, n_err = 0;
    logic [42:0] sb_q[$];

    always #5 clk = ~clk;

    fpnew_fma_sum_norm dut (
        .clk_i(clk), .rst_ni(rst_n), .effective_subtraction_i(es), .tentative_sign_i(ts),
        .tentative_exponent_i(te), .sticky_before_add_i(sb), .product_shifted_i(p),
        .addend_shifted_i(a), .inject_carry_in_i(c), .rnd_mode_i(rm_i), .tag_i(tag_i), .aux_i(aux_i),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .flush_i(flush), .sign_o(sign_o),
        .exponent_o(exponent_o), .mantissa_o(mant_o), .round_bit_o(round_o), .sticky_bit_o(sticky_o),
        .zero_o(zero_o), .rnd_mode_o(rm_o), .tag_o(tag_o), .aux_o(aux_o), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .busy_o(busy)
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", name, obs, want);
        end
    endtask

    function automatic logic [42:0] pack_out();
        return {sign_o, exponent_o, mant_o, round_o, sticky_o, zero_o, rm_o, tag_o, aux_o};
    endfunction

    function automatic logic [42:0] mk(logic s, logic [9:0] e, logic [23:0] m, logic r, logic st, logic z, logic [2:0] rm);
        return {s, e, m, r, st, z, rm, 1'b0, 1'b0};
    endfunction

    // Reference: exact sum as a magnitude, then normalize by the position of its top set bit.
    function automatic logic [42:0] model(input op_t o);
        logic [76:0] raw, mag, nrm;
        logic s, z;
        logic [9:0] ex;
        int lzc, e, sh;
        raw = {1'b0, o.p} + {1'b0, o.a} + {76'd0, o.c};
        s = o.ts;
        mag = raw;
        if (o.es) begin
            if (raw[76]) mag = {1'b0, raw[75:0]};
            else begin
                mag = {1'b0, 76'((77'd1 << 76) - {1'b0, raw[75:0]})};
                s = ~o.ts;
            end
        end
        z = (mag == 77'd0);
        lzc = 77;
        for (int i = 0; i < 77; i++) if (mag[i]) lzc = 76 - i;
        e = int'(o.te) + 1 - lzc;
        if (e < 1) begin
            sh = (o.te > 0) ? int'(o.te) : 0;
            ex = 10'd0;
        end else begin
            sh = lzc;
            ex = 10'(e);
        end
        nrm = mag << sh;
        if (z) begin
            ex = 10'd0;
            if (!o.sb) s = (o.rm == 3'd2);
        end
        return {s, ex, nrm[76:53], nrm[52], (|nrm[51:0]) | o.sb, z, o.rm, o.tag, o.aux};
    endfunction

    function automatic op_t cur_op();
        op_t o;
        o.es = es; o.ts = ts; o.sb = sb; o.c = c; o.tag = tag_i; o.aux = aux_i;
        o.te = te; o.p = p; o.a = a; o.rm = rm_i;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.p = 76'({$urandom, $urandom, $urandom}) >> $urandom_range(0, 75);
        o.a = 76'({$urandom, $urandom, $urandom}) >> $urandom_range(0, 75);
        o.es = 1'($urandom);
        o.c = o.es;
        if (o.es && $urandom_range(0, 3) == 0) o.a = ~o.p;
        o.ts = 1'($urandom);
        o.te = 10'(int'($urandom_range(0, 150)) - 20);
        o.sb = ($urandom_range(0, 3) == 0);
        o.rm = 3'($urandom_range(0, 4));
        o.tag = 1'($urandom);
        o.aux = 1'($urandom);
        return o;
    endfunction

    function automatic op_t dir_op(logic e_s, logic t_s, logic signed [9:0] t_e, logic [75:0] pp, logic [75:0] aa, logic cc, logic [2:0] rm);
        op_t o;
        o.es = e_s; o.ts = t_s; o.te = t_e; o.p = pp; o.a = aa; o.c = cc; o.rm = rm;
        o.sb = 1'b0; o.tag = 1'b0; o.aux = 1'b0;
        return o;
    endfunction

    task automatic drive(input op_t o);
        es = o.es; ts = o.ts; sb = o.sb; c = o.c; tag_i = o.tag; aux_i = o.aux;
        te = o.te; p = o.p; a = o.a; rm_i = o.rm;
    endtask

    task automatic run_op(input string name, input op_t o, input logic [42:0] want);
        int n = 0;
        drive(o);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (!out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) chk({name, "_timeout"}, 64'd0, 64'd1);
        else chk(name, pack_out(), want);
        @(posedge clk); #1;
    endtask

    // Scoreboard: every accepted input must come out once, in order, matching the model.
    always @(negedge clk) begin
        if (!rst_n) sb_q.delete();
        else begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) chk("unexpected_output", 64'd1, 64'd0);
                else chk("stream", pack_out(), sb_q.pop_front());
            end
            if (flush) sb_q.delete();
            else if (in_valid && in_ready) sb_q.push_back(model(cur_op()));
        end
    end

    initial begin
        int acc;
        int n;
        drive(dir_op(0, 0, 10'sd0, 76'd0, 76'd0, 0, 3'd0));
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", pack_out(), 43'd0);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_busy", busy, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("plain_add", dir_op(0, 1, 10'sd100, 76'd1 << 74, 76'd1 << 74, 0, 3'd0),
               mk(1, 10'd100, 24'h800000, 0, 0, 0, 3'd0));
        run_op("cancel_rne", dir_op(1, 1, 10'sd100, 76'd1 << 74, ~(76'd1 << 74), 1, 3'd0),
               mk(0, 10'd0, 24'h0, 0, 0, 1, 3'd0));
        run_op("cancel_rdn", dir_op(1, 0, 10'sd100, 76'd1 << 74, ~(76'd1 << 74), 1, 3'd2),
               mk(1, 10'd0, 24'h0, 0, 0, 1, 3'd2));
        run_op("negative", dir_op(1, 0, 10'sd100, 76'd1 << 70, ~(76'd1 << 72), 1, 3'd0),
               mk(1, 10'd96, 24'hC00000, 0, 0, 0, 3'd0));
        run_op("subnormal_clamp", dir_op(0, 0, 10'sd2, (76'd1 << 66) | (76'd1 << 55) | 76'd1, 76'd0, 0, 3'd1),
               mk(0, 10'd0, 24'h008010, 0, 1, 0, 3'd1));

        out_ready = 1'b0;
        acc = 0;
        for (int k = 0; k < 4; k++) begin
            drive(rand_op());
            in_valid = 1'b1;
            @(negedge clk);
            if (in_ready) acc++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("bp_accepted", 64'(acc), 64'd2);
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_out_valid_hold", out_valid, 1'b1);
        out_ready = 1'b1;
        @(negedge clk); chk("bp_drain0", out_valid, 1'b1);
        @(negedge clk); chk("bp_drain1", out_valid, 1'b1);
        @(negedge clk); chk("bp_drain_done", out_valid, 1'b0);
        chk("bp_no_loss", 64'(sb_q.size()), 64'd0);
        @(posedge clk); #1;

        out_ready = 1'b0;
        drive(rand_op()); in_valid = 1'b1;
        @(posedge clk); #1;
        drive(rand_op());
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_busy", busy, 1'b0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        drive(rand_op()); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("post_flush_complete", out_valid, 1'b1);
        @(posedge clk); #1;

        for (int k = 0; k < 600; k++) begin
            drive(rand_op());
            in_valid = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            flush = ($urandom_range(0, 39) == 0);
            if (k == 300) rst_n = 1'b0;
            if (k == 302) rst_n = 1'b1;
            if (k == 301) chk("midreset_out_valid", out_valid, 1'b0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("final_drain", 64'(sb_q.size()), 64'd0);
        chk("final_idle", busy, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
